// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit nandgame CPU; owns A, D, PC, IR and MDR.
// Optional jump-to-self halt detection is enabled by defining INSTR_SEQ_HALT_DETECT_EN.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata,
    output logic [15:0] ih_I,
    output logic [15:0] ih_A,
    output logic [15:0] ih_D,
    output logic [15:0] ih_addr_A,
    input  logic [15:0] ih_R,
    input  logic        ih_a,
    input  logic        ih_d,
    input  logic        ih_addr_a,
    input  logic        ih_j,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEMRD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEMWR  = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] pc_r;
    logic [15:0] a_r;
    logic [15:0] d_r;
    logic [15:0] ir_r;
    logic [15:0] mdr_r;
    logic [15:0] rq_r;
    logic        wa_r;
    logic        wd_r;
    logic        jq_r;

    // A stays constant across MEMRD/MEMWR, so the RAM address can follow A directly.
    assign rom_addr  = pc_r;
    assign ram_addr  = a_r;
    assign ram_wdata = rq_r;
    assign ih_I      = ir_r;
    assign ih_A      = a_r;
    assign ih_D      = d_r;
    assign ih_addr_A = mdr_r;
    assign pc        = pc_r;

`ifdef INSTR_SEQ_HALT_DETECT_EN
    assign halted = (state_r == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    // Next-state and handshake request decode.
    always_comb begin
        state_next_s = state_r;
        rom_req      = 1'b0;
        ram_rd       = 1'b0;
        ram_wr       = 1'b0;
        case (state_r)
            ST_FETCH: begin
                rom_req = run;
                if (run && rom_ack) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!ir_r[15]) begin
                    state_next_s = ST_FETCH;
                end else if (ir_r[12]) begin
                    state_next_s = ST_MEMRD;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_MEMRD: begin
                ram_rd = 1'b1;
                if (ram_ack) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_MEMRD;
                end
            end
            ST_EXEC: begin
                if (ih_addr_a) begin
                    state_next_s = ST_MEMWR;
                end else begin
                    state_next_s = ST_COMMIT;
                end
            end
            ST_MEMWR: begin
                ram_wr = 1'b1;
                if (ram_ack) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_MEMWR;
                end
            end
            ST_COMMIT: begin
`ifdef INSTR_SEQ_HALT_DETECT_EN
                if (jq_r && (a_r == pc_r)) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
`else
                state_next_s = ST_FETCH;
`endif
            end
`ifdef INSTR_SEQ_HALT_DETECT_EN
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
`endif
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Architectural and handler-result registers; COMMIT uses the pre-instruction A for the jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r  <= RESET_PC;
            a_r   <= 16'h0000;
            d_r   <= 16'h0000;
            ir_r  <= 16'h0000;
            mdr_r <= 16'h0000;
            rq_r  <= 16'h0000;
            wa_r  <= 1'b0;
            wd_r  <= 1'b0;
            jq_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (run && rom_ack) begin
                        ir_r <= rom_data;
                    end
                end
                ST_DECODE: begin
                    if (!ir_r[15]) begin
                        a_r  <= ir_r;
                        pc_r <= pc_r + 16'd1;
                    end else if (!ir_r[12]) begin
                        mdr_r <= 16'h0000;
                    end
                end
                ST_MEMRD: begin
                    if (ram_ack) begin
                        mdr_r <= ram_rdata;
                    end
                end
                ST_EXEC: begin
                    rq_r <= ih_R;
                    wa_r <= ih_a;
                    wd_r <= ih_d;
                    jq_r <= ih_j;
                end
                ST_COMMIT: begin
                    pc_r <= jq_r ? a_r : (pc_r + 16'd1);
                    if (wa_r) begin
                        a_r <= rq_r;
                    end
                    if (wd_r) begin
                        d_r <= rq_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Table-driven bench for instr_sequencer: a ROM/RAM responder with configurable wait states plus
// hand-written sequences for jump-to-self, run=0 and reset during a RAM read.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b1;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = 16'h0000;
    logic        ram_rd;
    logic        ram_wr;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata = 16'h0000;
    logic [15:0] ih_I;
    logic [15:0] ih_A;
    logic [15:0] ih_D;
    logic [15:0] ih_addr_A;
    logic [15:0] ih_R = 16'h0000;
    logic        ih_a = 1'b0;
    logic        ih_d = 1'b0;
    logic        ih_addr_a = 1'b0;
    logic        ih_j = 1'b0;
    logic [15:0] pc;
    logic        halted;

    instr_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .ih_I(ih_I), .ih_A(ih_A), .ih_D(ih_D), .ih_addr_A(ih_addr_A),
        .ih_R(ih_R), .ih_a(ih_a), .ih_d(ih_d), .ih_addr_a(ih_addr_a), .ih_j(ih_j),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] r;
        logic        a;
        logic        d;
        logic        m;
        logic        j;
        logic [15:0] rdata;
        int          wt;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [15:0] epc;
        int          elat;
        int          nrd;
        logic [15:0] rd_addr;
        logic [15:0] emdr;
        int          nwr;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
    } vec_t;

    vec_t        tbl [14];
    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          excl_n = 0;
    int          ram_cnt = 0;
    int          ram_wait = 0;
    logic        rom_allow = 1'b0;
    logic [15:0] cur_instr = 16'h0000;
    logic        mdr_pending = 1'b0;
    int          rd_n, wr_n;
    logic [15:0] rd_addr_log, wr_addr_log, wr_data_log, mdr_log;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: wait for the falling edge, then sample outputs and drive the ROM/RAM responses.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if ((ram_rd && ram_wr) || (rom_req && (ram_rd || ram_wr))) excl_n++;
        if (mdr_pending) begin
            mdr_log     = ih_addr_A;
            mdr_pending = 1'b0;
        end
        rom_ack  = rom_req && rom_allow;
        rom_data = cur_instr;
        if (ram_rd || ram_wr) begin
            if (ram_cnt >= ram_wait) begin
                ram_ack = 1'b1;
                ram_cnt = 0;
                if (ram_rd) begin
                    rd_n++;
                    rd_addr_log = ram_addr;
                    mdr_pending = 1'b1;
                end else begin
                    wr_n++;
                    wr_addr_log = ram_addr;
                    wr_data_log = ram_wdata;
                end
            end else begin
                ram_ack = 1'b0;
                ram_cnt++;
            end
        end else begin
            ram_ack = 1'b0;
            ram_cnt = 0;
        end
    endtask

    task automatic fetch_one(input string nm);
        int n;
        n = 0;
        rom_allow = 1'b1;
        do begin
            cycle();
            n++;
        end while (!rom_ack && n < 60);
        check({nm, "_fetch_ack"}, {31'd0, rom_ack}, 32'd1);
        rom_allow = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ram_cnt = 0;
        rom_allow = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int t0, n, reqs;
        logic [15:0] prev_pc;
        logic [15:0] last_rom_addr;

        tbl[0]  = '{16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0005, 16'h0000, 16'h0001,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[1]  = '{16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0006, 16'h0000, 16'h0002,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[2]  = '{16'hE010, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0006, 16'h0007, 16'h0003,  4, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[3]  = '{16'h002A, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h002A, 16'h0007, 16'h0004,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[4]  = '{16'hF008, 16'h1235, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 3, 16'h002A, 16'h0007, 16'h0005, 12, 1, 16'h002A, 16'h1234, 1, 16'h002A, 16'h1235};
        tbl[5]  = '{16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0010, 16'h0007, 16'h0006,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[6]  = '{16'hE007, 16'h0099, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0099, 16'h0007, 16'h0010,  4, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[7]  = '{16'hE000, 16'h00AB, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 16'h00AB, 16'h00AB, 16'h0099,  5, 0, 16'h0000, 16'h0000, 1, 16'h0099, 16'h00AB};
        tbl[8]  = '{16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h7FFF, 16'h00AB, 16'h009A,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[9]  = '{16'hE000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'hFFFF, 16'h00AB, 16'h009B,  4, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[10] = '{16'hE000, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'hFFFF, 16'h00AB, 16'hFFFF,  4, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[11] = '{16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0003, 16'h00AB, 16'h0000,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[12] = '{16'hF000, 16'h5556, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 0, 16'h0003, 16'h5556, 16'h0001,  5, 1, 16'h0003, 16'h5555, 0, 16'h0000, 16'h0000};
        tbl[13] = '{16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0002, 16'h5556, 16'h0002,  2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};

        do_reset();
        check("rst_pc", {16'd0, pc}, 32'h0000);
        check("rst_A", {16'd0, ih_A}, 32'h0000);
        check("rst_D", {16'd0, ih_D}, 32'h0000);
        check("rst_IR", {16'd0, ih_I}, 32'h0000);
        check("rst_MDR", {16'd0, ih_addr_A}, 32'h0000);
        check("rst_ram_req", {30'd0, ram_rd, ram_wr}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_rom_req", {31'd0, rom_req}, 32'd1);

        prev_pc = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            cur_instr   = tbl[i].instr;
            ih_R        = tbl[i].r;
            ih_a        = tbl[i].a;
            ih_d        = tbl[i].d;
            ih_addr_a   = tbl[i].m;
            ih_j        = tbl[i].j;
            ram_rdata   = tbl[i].rdata;
            ram_wait    = tbl[i].wt;
            rd_n        = 0;
            wr_n        = 0;
            rd_addr_log = 16'hDEAD;
            wr_addr_log = 16'hDEAD;
            wr_data_log = 16'hDEAD;
            mdr_log     = 16'hDEAD;
            fetch_one($sformatf("v%0d", i));
            check($sformatf("v%0d_rom_addr", i), {16'd0, rom_addr}, {16'd0, prev_pc});
            t0 = cyc;
            n  = 0;
            do begin
                cycle();
                n++;
            end while (!rom_req && n < 60);
            check($sformatf("v%0d_latency", i), cyc - t0, tbl[i].elat);
            check($sformatf("v%0d_A", i), {16'd0, ih_A}, {16'd0, tbl[i].ea});
            check($sformatf("v%0d_D", i), {16'd0, ih_D}, {16'd0, tbl[i].ed});
            check($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, tbl[i].epc});
            check($sformatf("v%0d_IR", i), {16'd0, ih_I}, {16'd0, tbl[i].instr});
            check($sformatf("v%0d_nrd", i), rd_n, tbl[i].nrd);
            check($sformatf("v%0d_nwr", i), wr_n, tbl[i].nwr);
            if (tbl[i].nrd > 0) begin
                check($sformatf("v%0d_rd_addr", i), {16'd0, rd_addr_log}, {16'd0, tbl[i].rd_addr});
                check($sformatf("v%0d_exec_mdr", i), {16'd0, mdr_log}, {16'd0, tbl[i].emdr});
            end
            if (tbl[i].nwr > 0) begin
                check($sformatf("v%0d_wr_addr", i), {16'd0, wr_addr_log}, {16'd0, tbl[i].wr_addr});
                check($sformatf("v%0d_wr_data", i), {16'd0, wr_data_log}, {16'd0, tbl[i].wr_data});
            end
            prev_pc = tbl[i].epc;
        end

        // Jump-to-self at PC=2 with A=2.
        cur_instr = 16'hE000;
        ih_R = 16'h0000; ih_a = 1'b0; ih_d = 1'b0; ih_addr_a = 1'b0; ih_j = 1'b1;
        ram_wait = 0;
        fetch_one("self");
        cycle();
        cycle();
        cycle();
        reqs = 0;
        last_rom_addr = 16'hDEAD;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (rom_req || ram_rd || ram_wr) reqs++;
            if (rom_req) last_rom_addr = rom_addr;
        end
`ifdef INSTR_SEQ_HALT_DETECT_EN
        check("self_halted", {31'd0, halted}, 32'd1);
        check("self_reqs", reqs, 0);
`else
        check("self_halted", {31'd0, halted}, 32'd0);
        check("self_reqs", reqs, 20);
        check("self_refetch_addr", {16'd0, last_rom_addr}, 32'h0002);
`endif

        // run drops while a compute instruction is in flight: it completes, no new fetch.
        do_reset();
        cur_instr = 16'hE000;
        ih_R = 16'h0042; ih_a = 1'b0; ih_d = 1'b1; ih_addr_a = 1'b0; ih_j = 1'b0;
        fetch_one("run0");
        cycle();
        run = 1'b0;
        reqs = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (rom_req) reqs++;
        end
        check("run0_rom_req", reqs, 0);
        check("run0_pc", {16'd0, pc}, 32'h0001);
        check("run0_D", {16'd0, ih_D}, 32'h0042);
        run = 1'b1;

        // Reset asserted while a RAM read is stalled.
        cur_instr = 16'hF000;
        ih_d = 1'b0;
        ram_wait = 1000;
        fetch_one("rstrd");
        n = 0;
        do begin
            cycle();
            n++;
        end while (!ram_rd && n < 20);
        check("rstrd_ram_rd_seen", {31'd0, ram_rd}, 32'd1);
        rst = 1'b1;
        cycle();
        check("rstrd_ram_rd", {31'd0, ram_rd}, 32'd0);
        check("rstrd_pc", {16'd0, pc}, 32'h0000);
        check("rstrd_D", {16'd0, ih_D}, 32'h0000);
        rst = 1'b0;
        ram_wait = 0;
        cycle();

        check("mutual_exclusion", excl_n, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
